// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation in flight; result returned on the owner's response port.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_carry,
    output logic             resp_overflow,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   gnt0;
    logic   gnt1;
    logic   take;
    logic   resp_take;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_grant);
        gnt1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready = (state == IDLE) & gnt0;
    assign req1_ready = (state == IDLE) & gnt1;
    assign take       = req0_ready | req1_ready;
    assign resp_take  = (state == RESP) & (owner ? resp1_ready : resp0_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            alu_enable    <= 1'b0;
            resp0_valid   <= 1'b0;
            resp1_valid   <= 1'b0;
            resp_result   <= '0;
            resp_zero     <= 1'b0;
            resp_carry    <= 1'b0;
            resp_overflow <= 1'b0;
            busy          <= 1'b0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        alu_a      <= req1_ready ? req1_a  : req0_a;
                        alu_b      <= req1_ready ? req1_b  : req0_b;
                        alu_op     <= req1_ready ? req1_op : req0_op;
                        owner      <= req1_ready;
                        last_grant <= req1_ready;
                        alu_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_enable <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    resp_result   <= alu_result;
                    resp_zero     <= alu_zero;
                    resp_carry    <= alu_carry;
                    resp_overflow <= alu_overflow;
                    resp0_valid   <= ~owner;
                    resp1_valid   <= owner;
                    state         <= RESP;
                end
                RESP: begin
                    if (resp_take) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        busy        <= 1'b0;
                        op_count    <= op_count + CNTW'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
